// File: rtl/matmul_job_sequencer.sv
// Sequences one matrix-multiply job: streams X then Y into the multiplier RAM,
// kicks the multiplier, then streams Z back out with a valid/ready handshake.
module matmul_job_sequencer #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_start,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  mm_start,
  input  logic                  mm_busy,
  output logic [ADDR_WIDTH-1:0] mm_ram_addr,
  output logic                  mm_ram_wen,
  output logic [1:0]            mm_ram_sel,
  output logic [DATA_WIDTH-1:0] mm_ram_data_in,
  input  logic [DATA_WIDTH-1:0] mm_ram_data_out,
  output logic [3:0]            dbg_state
);

  localparam int NX     = X_ROWS * X_COLS_Y_ROWS;
  localparam int NY     = X_COLS_Y_ROWS * Y_COLS;
  localparam int NZ     = X_ROWS * Y_COLS;
  localparam int MAX_XY = (NX > NY) ? NX : NY;
  localparam int MAX_N  = (MAX_XY > NZ) ? MAX_XY : NZ;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] NX_LAST = CNT_W'(NX - 1);
  localparam logic [CNT_W-1:0] NY_LAST = CNT_W'(NY - 1);
  localparam logic [CNT_W-1:0] NZ_LAST = CNT_W'(NZ - 1);

  localparam logic [1:0] SEL_X = 2'b00;
  localparam logic [1:0] SEL_Y = 2'b01;
  localparam logic [1:0] SEL_Z = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_X    = 4'd1,
    LOAD_Y    = 4'd2,
    START     = 4'd3,
    WAIT_BUSY = 4'd4,
    RUN       = 4'd5,
    READ_Z    = 4'd6,
    CAPTURE   = 4'd7,
    OUT       = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [2:0]              wait_cnt, wait_nxt;
  logic                    err_nxt;
  logic                    valid_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    last_nxt;

  assign dbg_state = state;

  // Handshakes: a word moves on a rising edge where valid & ready are both 1;
  // the producer holds valid and its data stable until that edge.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    wait_nxt       = wait_cnt;
    err_nxt        = job_err;
    valid_nxt      = out_valid;
    data_nxt       = out_data;
    last_nxt       = out_last;
    in_ready       = 1'b0;
    mm_ram_wen     = 1'b0;
    mm_ram_sel     = SEL_Z;
    mm_ram_addr    = ADDR_WIDTH'(cnt);
    mm_ram_data_in = '0;
    mm_start       = 1'b0;
    job_done       = 1'b0;
    job_busy       = 1'b1;

    unique case (state)
      IDLE: begin
        job_busy    = 1'b0;
        mm_ram_sel  = SEL_X;
        mm_ram_addr = '0;
        if (job_start) begin
          state_nxt = LOAD_X;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      LOAD_X: begin
        in_ready   = 1'b1;
        mm_ram_sel = SEL_X;
        if (in_valid) begin
          mm_ram_wen     = 1'b1;
          mm_ram_data_in = in_data;
          if (cnt == NX_LAST) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_Y;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOAD_Y: begin
        in_ready   = 1'b1;
        mm_ram_sel = SEL_Y;
        if (in_valid) begin
          mm_ram_wen     = 1'b1;
          mm_ram_data_in = in_data;
          if (cnt == NY_LAST) begin
            cnt_nxt   = '0;
            state_nxt = START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      START: begin
        mm_start  = 1'b1;
        wait_nxt  = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Eight cycles to see busy; a dead multiplier still yields a Z readout.
        if (mm_busy) begin
          state_nxt = RUN;
        end else if (wait_cnt == 3'd7) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = READ_Z;
        end else begin
          wait_nxt = wait_cnt + 3'd1;
        end
      end
      RUN: begin
        if (!mm_busy) begin
          cnt_nxt   = '0;
          state_nxt = READ_Z;
        end
      end
      READ_Z: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        valid_nxt = 1'b1;
        data_nxt  = mm_ram_data_out;
        last_nxt  = (cnt == NZ_LAST);
        state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (out_last) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = READ_Z;
          end
        end
      end
      DONE: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset wins over any in-flight handshake in the same cycle.
    if (rst) begin
      in_ready       = 1'b0;
      mm_ram_wen     = 1'b0;
      mm_ram_sel     = SEL_X;
      mm_ram_addr    = '0;
      mm_ram_data_in = '0;
      mm_start       = 1'b0;
      job_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wait_cnt  <= '0;
      job_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wait_cnt  <= wait_nxt;
      job_err   <= err_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_last  <= last_nxt;
    end
  end

endmodule
